// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with synchronous, active-high reset.
// Leaf storage cell of the gate-level datapath. It has no enable of its own;
// enabled registers wrap one instance per bit with an external AND/OR mux.
// Each bit of q depends only on the matching bit of d and on reset.

module d_ff #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next state is the raw data input; reset takes priority inside the flop.
    always_comb begin
        q_d = d;
    end

    // Capture d on every rising edge; synchronous reset wins over d.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    // No combinational path from d or reset: q is the register itself.
    assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Testbench for d_ff: a 1-bit default cell, a 4-bit enabled register built
// from four cells plus a 50 ps AND/OR enable mux, and an 8-bit cell with a
// non-zero reset value. Expected values come from a small behavioural model.

`timescale 1ps / 1ps

module tb_d_ff;

    typedef struct packed {
        logic       e1;
        logic [3:0] e4;
        logic [7:0] e8;
    } exp_t;

    logic clk;

    // 1-bit default instance
    logic r1, d1, q1;
    // 4-bit gate-level enabled register
    logic       r4, en4;
    logic [3:0] d4, q4, dm4, a1_4, a0_4;
    logic       en4_n;
    // 8-bit instance with reset value 8'hA5
    logic       r8;
    logic [7:0] d8, q8;

    // Model state
    logic       m1;
    logic [3:0] m4;
    logic [7:0] m8;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    initial begin
        clk = 1'b0;
        forever #500 clk = ~clk;
    end

    d_ff u_dut1 (
        .clk   (clk),
        .reset (r1),
        .d     (d1),
        .q     (q1)
    );

    // Enable mux: dm = (en & d) | (~en & q), each gate 50 ps.
    assign #50 en4_n = ~en4;
    assign #50 a1_4  = {4{en4}} & d4;
    assign #50 a0_4  = {4{en4_n}} & q4;
    assign #50 dm4   = a1_4 | a0_4;

    for (genvar gi = 0; gi < 4; gi++) begin : g_reg4
        d_ff u_bit (
            .clk   (clk),
            .reset (r4),
            .d     (dm4[gi]),
            .q     (q4[gi])
        );
    end

    d_ff #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (r8),
        .d     (d8),
        .q     (q8)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour at a rising edge, from the inputs present now.
    task automatic model_edge();
        m1 = r1 ? 1'b0 : d1;
        m4 = r4 ? 4'h0 : (en4 ? d4 : m4);
        m8 = r8 ? 8'hA5 : d8;
    endtask

    // Push expectation for the coming edge, then compare after it.
    task automatic expect_edge(input string tag);
        exp_t e;
        model_edge();
        sb_q.push_back('{e1: m1, e4: m4, e8: m8});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".q1"}, {7'd0, q1}, {7'd0, e.e1});
            check_eq({tag, ".q4"}, {4'd0, q4}, {4'd0, e.e4});
            check_eq({tag, ".q8"}, q8, e.e8);
        end
    endtask

    task automatic step(input string tag,
                        input logic rr1, input logic dd1,
                        input logic rr4, input logic [3:0] dd4, input logic ee4,
                        input logic rr8, input logic [7:0] dd8);
        @(negedge clk);
        r1 = rr1; d1 = dd1;
        r4 = rr4; d4 = dd4; en4 = ee4;
        r8 = rr8; d8 = dd8;
        #200;  // let the enable mux settle before the edge
        expect_edge(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        r1 = 1'b1; d1 = 1'b1;
        r4 = 1'b1; d4 = 4'hF; en4 = 1'b1;
        r8 = 1'b1; d8 = 8'h3C;
        m1 = 1'b0; m4 = 4'h0; m8 = 8'h00;

        // Reset with d=1, then hold reset while d toggles
        step("rst0", 1, 1, 1, 4'hF, 1, 1, 8'h3C);
        step("rst1", 1, 0, 1, 4'h0, 1, 1, 8'hFF);
        step("rst2", 1, 1, 1, 4'hF, 0, 1, 8'h00);
        step("rst3", 1, 0, 1, 4'hA, 1, 1, 8'h5A);

        // Capture and gate-level register sequence
        step("cap1",  0, 1, 0, 4'hF, 0, 0, 8'h3C);  // reg4 holds 0000
        step("cap0",  0, 0, 0, 4'hF, 1, 0, 8'hC3);  // reg4 loads 1111
        step("hold5", 0, 1, 0, 4'h5, 0, 0, 8'h00);  // reg4 holds 1111
        step("load5", 0, 0, 0, 4'h5, 1, 0, 8'hFF);  // reg4 loads 0101
        step("zero",  0, 1, 0, 4'h0, 1, 0, 8'h3C);  // reg4 loads 0000

        // Bit independence: walking one and walking zero
        for (int i = 0; i < 8; i++) begin
            step("walk1", 0, i[0], 0, 4'(i), i[1], 0, 8'(1 << i));
            step("walk0", 0, ~i[0], 0, ~4'(i), 1, 0, ~8'(1 << i));
        end

        // d toggles inside high phase, then low phase: q moves only on rising edges
        step("pre_tog", 0, 1, 0, 4'h3, 1, 0, 8'h3C);
        #99;  d1 = 1'b0;
        #100; check_eq("tog_hi_a", {7'd0, q1}, {7'd0, m1});
        d1 = 1'b1;
        #100; check_eq("tog_hi_b", {7'd0, q1}, {7'd0, m1});
        d1 = 1'b0;
        @(negedge clk);
        #1;   check_eq("tog_fall", {7'd0, q1}, {7'd0, m1});
        d1 = 1'b1;
        #100; check_eq("tog_lo_a", {7'd0, q1}, {7'd0, m1});
        d1 = 1'b0;
        #100; check_eq("tog_lo_b", {7'd0, q1}, {7'd0, m1});
        d1 = 1'b1;
        #100;
        expect_edge("tog_edge");

        // Reset asserted 100 ps after an edge takes effect only at the next edge
        step("sr_pre", 0, 1, 0, 4'h3, 1, 0, 8'h3C);
        #99;  r1 = 1'b1;
        #100; check_eq("sr_mid", {7'd0, q1}, 8'd1);
        @(negedge clk);
        #1;   check_eq("sr_fall", {7'd0, q1}, 8'd1);
        #200;
        expect_edge("sr_edge");
        // Deassert mid-cycle with d=1: q rises only after the following edge
        #299; r1 = 1'b0; d1 = 1'b1;
        #100; check_eq("sr_rel_mid", {7'd0, q1}, 8'd0);
        @(negedge clk);
        #1;   check_eq("sr_rel_fall", {7'd0, q1}, 8'd0);
        #200;
        expect_edge("sr_rel_edge");

        // Reset priority on the 4- and 8-bit paths with non-zero d
        step("rst_pri", 0, 1, 1, 4'hF, 1, 1, 8'h3C);
        step("post_rst", 0, 1, 0, 4'h9, 1, 0, 8'h3C);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
